inst_refill_controller: RTL
===========================

Name: inst_refill_controller

Overview:
Instruction-side miss handler that sits directly upstream of the thread-management block. It accepts instruction-cache misses from the ID stage and drops duplicate misses. It queues one outstanding line refill per hardware thread and runs burst reads to external memory. It writes returned words into the instruction cache. On completion it reports DoneRetrieving/RetrievingDoneFor/InstReady/InstAddress, and while busy it reports InstRead/FetchingAddress, so the thread scheduler can wake or park threads.

Parameters:
NUM_THREADS, 4, hardware threads; TID width = $clog2(NUM_THREADS)
LINE_WORDS, 4, 32-bit words per cache line (power of two)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
nReset  in  1  asynchronous active-low reset
InstMiss  in  1  I-cache miss for the instruction in ID (single-cycle pulse)
MissAddress  in  ADDR_W  word address that missed
MissTID  in  TID_W  hart ID owning the miss (mhartID_ID)
IgnoreMiss  out  1  combinational; miss is a duplicate and is not queued
InstRead  out  1  refill in flight (REQ or BEAT state)
FetchingAddress  out  ADDR_W  miss address of the head entry; 0 when idle
InstReady  out  1  one-cycle pulse; refill complete
InstAddress  out  ADDR_W  miss address of the completed refill, valid with InstReady
DoneRetrieving  out  1  one-cycle pulse, coincident with InstReady
RetrievingDoneFor  out  TID_W  thread whose refill completed
MemReq  out  1  external read request
MemAddr  out  ADDR_W  line-aligned burst base address
MemAck  in  1  request accepted (one cycle)
MemValid  in  1  read data beat valid
MemRdata  in  32  read data beat
FillWe  out  1  I-cache line-fill write enable
FillAddr  out  ADDR_W  word address being filled
FillData  out  32  fill word (= MemRdata)

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE, per-thread pending bits cleared. Reset mid-burst abandons the burst. MemValid arriving after reset is ignored because IDLE never writes.
- Queue: FIFO of depth NUM_THREADS. Each entry holds {tid, miss address}. pending[tid] is set on enqueue and cleared on pop.
- Duplicate filter (combinational): IgnoreMiss = InstMiss && (pending[MissTID] || line(MissAddress) matches the line of any valid entry, head included || queue full). line(a) = a with the low log2(LINE_WORDS*4) bits zeroed.
- Enqueue: on InstMiss && !IgnoreMiss, the entry is written at the clock edge and is visible next cycle. Enqueue and pop in the same cycle are both honoured.
- FSM:
  - IDLE: if the queue is non-empty, go to REQ.
  - REQ: MemReq=1, MemAddr=line(head addr); hold until MemAck, then go to BEAT with beat=0.
  - BEAT: on each MemValid, FillWe=1, FillAddr=line(head)+4*beat, FillData=MemRdata, beat++. On the beat with beat==LINE_WORDS-1, go to DONE. Cycles without MemValid wait with no timeout.
  - DONE (one cycle): InstReady=DoneRetrieving=1, RetrievingDoneFor=head tid, InstAddress=head addr; pop head, clear pending[tid]. Go to REQ if entries remain after the pop (including a same-cycle enqueue), else IDLE.
- InstRead=1 in REQ and BEAT. FetchingAddress=head addr in REQ/BEAT/DONE, else 0.
- Latency: a miss at cycle t gives REQ at t+2 when the queue was empty. DONE comes one cycle after the final beat.
- Beat counter width is log2(LINE_WORDS) and wraps naturally. FillAddr addition is modulo 2^ADDR_W.
- A miss for a line matching the head during DONE is ignored: the line is already filled that cycle.
- Full queue cannot occur with legal stimulus (at most one miss per thread). The bench asserts it never fires; if it does, the miss is ignored.

Decomposition:
- Package riscv_mt_pkg: TID_W, LINE_BYTES, the line-align function, and the refill FSM state enum (IDLE, REQ, BEAT, DONE).
- One sub-module: refill_queue, a parameterised FIFO exposing the head entry, an all-entry line-match compare, and the pending vector.

Test Plan:
- Single miss: InstMiss, tid 2, addr 0x104. Expect MemReq with MemAddr 0x100 at t+2. After MemAck and 4 beats (D0..D3), FillAddr runs 0x100..0x10C, then a DONE pulse with RetrievingDoneFor=2 and InstAddress=0x104.
- Duplicate line: tid 0 misses 0x200 and tid 1 misses 0x208 while tid 0's refill is in flight. Expect IgnoreMiss=1 for tid 1, and only one burst with one DoneRetrieving (tid 0).
- Back-to-back queueing: tids 0, 1, 3 miss lines 0x000, 0x040, 0x080 in consecutive cycles. Expect three serial bursts in FIFO order and DONE pulses for tid 0, 1, 3. REQ follows DONE directly with no IDLE cycle.
- Enqueue during DONE: tid 3 misses 0x300 in the same cycle tid 1's DONE fires. Expect the 0x300 entry accepted and the next state REQ with MemAddr 0x300.
- Gapped beats: MemValid asserted on alternate cycles. Expect FillWe only on valid cycles, beat count correct, and DONE one cycle after the 4th beat.
- Reset mid-burst: drop nReset after 2 beats, keep MemValid toggling. Expect all outputs 0, no FillWe, and a queue empty on release.

Source files
------------

// File: rtl/riscv_mt_pkg.sv
// Shared types and constants for the multithreaded instruction-side refill path.
package riscv_mt_pkg;
    localparam int MT_NUM_THREADS = 4;
    localparam int MT_LINE_WORDS  = 4;
    localparam int MT_ADDR_W      = 32;
    localparam int TID_W          = $clog2(MT_NUM_THREADS);
    localparam int LINE_BYTES     = MT_LINE_WORDS * 4;
    localparam int LINE_OFF_W     = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BEAT,
        DONE
    } refill_state_e;

    function automatic logic [MT_ADDR_W-1:0] line_align(input logic [MT_ADDR_W-1:0] addr);
        return {addr[MT_ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/refill_queue.sv
// FIFO of outstanding line refills, one slot per thread, with a line-match
// compare across every valid slot and a per-thread pending vector.
module refill_queue
    import riscv_mt_pkg::*;
#(
    parameter int DEPTH = MT_NUM_THREADS,
    parameter int TW    = TID_W,
    parameter int AW    = MT_ADDR_W
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  logic [TW-1:0]    push_tid,
    input  logic [AW-1:0]    push_addr,
    input  logic             pop,
    input  logic [AW-1:0]    match_addr,
    output logic             line_match,
    output logic             full,
    output logic             head_valid,
    output logic             more_than_one,
    output logic [TW-1:0]    head_tid,
    output logic [AW-1:0]    head_addr,
    output logic [DEPTH-1:0] pending
);
    localparam int PW = $clog2(DEPTH);

    logic [TW-1:0]    tid_q  [DEPTH];
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            pending <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tid_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            // Pop is applied first so a same-cycle push to a freed thread wins.
            if (pop) begin
                valid_q[rd_ptr]        <= 1'b0;
                pending[tid_q[rd_ptr]] <= 1'b0;
                rd_ptr                 <= rd_ptr + PW'(1);
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                tid_q[wr_ptr]   <= push_tid;
                addr_q[wr_ptr]  <= push_addr;
                pending[push_tid] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_comb begin
        line_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (line_align(addr_q[i]) == line_align(match_addr)))
                line_match = 1'b1;
        end
    end

    assign full          = (count == (PW+1)'(DEPTH));
    assign head_valid    = (count != '0);
    assign more_than_one = (count > (PW+1)'(1));
    assign head_tid      = tid_q[rd_ptr];
    assign head_addr     = addr_q[rd_ptr];
endmodule

// File: rtl/inst_refill_controller.sv
// Instruction-cache miss handler: filters duplicate misses, queues one refill
// per thread and runs line bursts to external memory in FIFO order.
//
// state | meaning
// IDLE  | queue empty, nothing in flight
// REQ   | burst request for the head line held until MemAck
// BEAT  | collecting LINE_WORDS data beats into the I-cache
// DONE  | one-cycle completion report, head popped
module inst_refill_controller
    import riscv_mt_pkg::*;
#(
    parameter int NUM_THREADS = MT_NUM_THREADS,
    parameter int LINE_WORDS  = MT_LINE_WORDS,
    parameter int ADDR_W      = MT_ADDR_W
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic                           InstMiss,
    input  logic [ADDR_W-1:0]              MissAddress,
    input  logic [$clog2(NUM_THREADS)-1:0] MissTID,
    output logic                           IgnoreMiss,
    output logic                           InstRead,
    output logic [ADDR_W-1:0]              FetchingAddress,
    output logic                           InstReady,
    output logic [ADDR_W-1:0]              InstAddress,
    output logic                           DoneRetrieving,
    output logic [$clog2(NUM_THREADS)-1:0] RetrievingDoneFor,
    output logic                           MemReq,
    output logic [ADDR_W-1:0]              MemAddr,
    input  logic                           MemAck,
    input  logic                           MemValid,
    input  logic [31:0]                    MemRdata,
    output logic                           FillWe,
    output logic [ADDR_W-1:0]              FillAddr,
    output logic [31:0]                    FillData
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int BW = $clog2(LINE_WORDS);

    refill_state_e     state, state_nx;
    logic [BW-1:0]     beat, beat_nx;
    logic              q_push, q_pop;
    logic              q_line_match, q_full, q_head_valid, q_more;
    logic [TW-1:0]     q_head_tid;
    logic [ADDR_W-1:0] q_head_addr;
    logic [ADDR_W-1:0] head_line;
    logic [NUM_THREADS-1:0] q_pending;

    refill_queue #(
        .DEPTH (NUM_THREADS),
        .TW    (TW),
        .AW    (ADDR_W)
    ) u_queue (
        .clk           (clk),
        .nReset        (nReset),
        .push          (q_push),
        .push_tid      (MissTID),
        .push_addr     (MissAddress),
        .pop           (q_pop),
        .match_addr    (MissAddress),
        .line_match    (q_line_match),
        .full          (q_full),
        .head_valid    (q_head_valid),
        .more_than_one (q_more),
        .head_tid      (q_head_tid),
        .head_addr     (q_head_addr),
        .pending       (q_pending)
    );

    // The head stays valid through DONE, so a miss on the line being completed is dropped.
    assign IgnoreMiss = InstMiss && (q_pending[MissTID] || q_line_match || q_full);
    assign q_push     = InstMiss && !IgnoreMiss;
    assign head_line  = line_align(q_head_addr);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
        end
    end

    always_comb begin
        state_nx          = state;
        beat_nx           = beat;
        q_pop             = 1'b0;
        InstRead          = 1'b0;
        FetchingAddress   = '0;
        InstReady         = 1'b0;
        InstAddress       = '0;
        DoneRetrieving    = 1'b0;
        RetrievingDoneFor = '0;
        MemReq            = 1'b0;
        MemAddr           = '0;
        FillWe            = 1'b0;
        FillAddr          = '0;
        FillData          = '0;
        case (state)
            IDLE: begin
                if (q_head_valid) state_nx = REQ;
            end
            REQ: begin
                InstRead        = 1'b1;
                FetchingAddress = q_head_addr;
                MemReq          = 1'b1;
                MemAddr         = head_line;
                if (MemAck) begin
                    state_nx = BEAT;
                    beat_nx  = '0;
                end
            end
            BEAT: begin
                InstRead        = 1'b1;
                FetchingAddress = q_head_addr;
                if (MemValid) begin
                    FillWe   = 1'b1;
                    FillAddr = head_line + (ADDR_W'(beat) << 2);
                    FillData = MemRdata;
                    beat_nx  = beat + BW'(1);
                    if (beat == BW'(LINE_WORDS - 1)) state_nx = DONE;
                end
            end
            DONE: begin
                FetchingAddress   = q_head_addr;
                InstReady         = 1'b1;
                DoneRetrieving    = 1'b1;
                RetrievingDoneFor = q_head_tid;
                InstAddress       = q_head_addr;
                q_pop             = 1'b1;
                state_nx          = (q_more || q_push) ? REQ : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
